// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared FSM state, redirect cause codes and reset PC default
package core_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_e;
  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_TRAP     = 3'd1;
  localparam logic [2:0] CAUSE_MRET     = 3'd2;
  localparam logic [2:0] CAUSE_JALR     = 3'd3;
  localparam logic [2:0] CAUSE_BR       = 3'd4;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd5;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/redirect_prio.sv
// redirect_prio: fixed-priority redirect select (trap > mret > jalr > br) with misalign check
// Inputs are the already-gated requests and their targets; outputs are the chosen
// valid/pc/cause, purely combinational.
module redirect_prio
  import core_ctrl_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        jalr_req,
  input  logic [31:0] jalr_tgt,
  input  logic        br_req,
  input  logic [31:0] br_tgt,
  output logic        sel_valid,
  output logic [31:0] sel_pc,
  output logic [2:0]  sel_cause
);
  logic [31:0] jalr_pc;
  logic        jalr_mis;
  logic        br_mis;
  assign jalr_pc  = {jalr_tgt[31:1], 1'b0};
  assign jalr_mis = jalr_pc[1];
  assign br_mis   = |br_tgt[1:0];
  assign sel_valid = trap_req | mret_req | jalr_req | br_req;
  // a misaligned jalr/br target diverts to the trap handler
  assign sel_pc = trap_req ? trap_vec :
                  mret_req ? mepc :
                  jalr_req ? (jalr_mis ? trap_vec : jalr_pc) :
                  br_req   ? (br_mis ? trap_vec : br_tgt) : 32'h0;
  assign sel_cause = trap_req ? CAUSE_TRAP :
                     mret_req ? CAUSE_MRET :
                     jalr_req ? (jalr_mis ? CAUSE_MISALIGN : CAUSE_JALR) :
                     br_req   ? (br_mis ? CAUSE_MISALIGN : CAUSE_BR) : CAUSE_NONE;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: PC redirect / pipeline flush / debug halt controller
// Inputs: trap/mret/jalr/br requests with targets, level halt_req.
// Outputs (all registered): redir_valid/redir_pc/redir_cause strobe, flush_if/flush_id,
// fetch_stall and halt_ack.
module pc_redirect_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        jalr_req,
  input  logic [31:0] jalr_tgt,
  input  logic        br_req,
  input  logic [31:0] br_tgt,
  input  logic        halt_req,
  output logic        halt_ack,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [2:0]  redir_cause,
  output logic        flush_if,
  output logic        flush_id,
  output logic        fetch_stall
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cause_q, cause_d;
  logic        flush_q, flush_d;
  logic        halt_q, halt_d;
  logic        run, sel_valid;
  logic [31:0] sel_pc;
  logic [2:0]  sel_cause;
  assign run = state_q == ST_RUN;
  // only traps are honoured in FLUSH; nothing is honoured in HALT
  redirect_prio u_prio (
    .trap_req  (trap_req & (state_q != ST_HALT)),
    .trap_vec  (trap_vec),
    .mret_req  (mret_req & run),
    .mepc      (mepc),
    .jalr_req  (jalr_req & run),
    .jalr_tgt  (jalr_tgt),
    .br_req    (br_req & run),
    .br_tgt    (br_tgt),
    .sel_valid (sel_valid),
    .sel_pc    (sel_pc),
    .sel_cause (sel_cause)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = sel_valid;
    pc_d    = sel_valid ? sel_pc : pc_q;
    cause_d = sel_valid ? sel_cause : CAUSE_NONE;
    if (sel_valid) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else if (state_q == ST_RUN) begin
      state_d = halt_req ? ST_HALT : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      state_d = (cnt_q == 3'd0) ? ST_RUN : ST_FLUSH;
      cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
    end else begin
      state_d = halt_req ? ST_HALT : ST_RUN;
    end
    flush_d = state_d == ST_FLUSH;
    halt_d  = state_d == ST_HALT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      cause_q <= CAUSE_NONE;
      flush_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      flush_q <= flush_d;
      halt_q  <= halt_d;
    end
  end
  assign redir_valid = valid_q;
  assign redir_pc    = pc_q;
  assign redir_cause = cause_q;
  assign flush_if    = flush_q;
  assign flush_id    = flush_q;
  assign halt_ack    = halt_q;
  assign fetch_stall = halt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: table-driven and sequence checks for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
  localparam logic [31:0] RPC = 32'h0000_1000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_req = 1'b0, mret_req = 1'b0, jalr_req = 1'b0, br_req = 1'b0, halt_req = 1'b0;
  logic [31:0] trap_vec = 32'h0, mepc = 32'h0, jalr_tgt = 32'h0, br_tgt = 32'h0;
  logic        halt_ack, redir_valid, flush_if, flush_id, fetch_stall;
  logic [31:0] redir_pc;
  logic [2:0]  redir_cause;
  int          n_cmp = 0;
  int          n_bad = 0;
  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .mret_req(mret_req), .mepc(mepc),
    .jalr_req(jalr_req), .jalr_tgt(jalr_tgt),
    .br_req(br_req), .br_tgt(br_tgt),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_cause(redir_cause),
    .flush_if(flush_if), .flush_id(flush_id), .fetch_stall(fetch_stall)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic trap, mret, jalr, br;
    logic [31:0] tv, ep, jt, bt;
    logic valid;
    logic [31:0] pc;
    logic [2:0] cause;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic v_e, input logic [31:0] pc_e, input logic [2:0] c_e,
                         input logic fl_e, input logic h_e);
    chk({tag, ".valid"}, 32'(redir_valid), 32'(v_e));
    chk({tag, ".pc"}, redir_pc, pc_e);
    chk({tag, ".cause"}, 32'(redir_cause), 32'(c_e));
    chk({tag, ".flush"}, {30'b0, flush_if, flush_id}, {30'b0, fl_e, fl_e});
    chk({tag, ".halt"}, {30'b0, halt_ack, fetch_stall}, {30'b0, h_e, h_e});
  endtask
  task automatic clr();
    trap_req = 0; mret_req = 0; jalr_req = 0; br_req = 0;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  initial begin
    v[0] = '{0,0,1,1, 32'h800, 32'h0,  32'h105,  32'h200, 1, 32'h104,  3'd3};
    v[1] = '{0,0,0,1, 32'h900, 32'h0,  32'h0,    32'h202, 1, 32'h900,  3'd5};
    v[2] = '{0,0,0,1, 32'h900, 32'h0,  32'h0,    32'h300, 1, 32'h300,  3'd4};
    v[3] = '{1,1,1,1, 32'hA00, 32'h80, 32'h100,  32'h200, 1, 32'hA00,  3'd1};
    v[4] = '{0,1,1,0, 32'hA00, 32'h80, 32'h100,  32'h200, 1, 32'h80,   3'd2};
    v[5] = '{0,0,1,0, 32'hB00, 32'h0,  32'h107,  32'h0,   1, 32'hB00,  3'd5};
    v[6] = '{0,0,1,0, 32'hB00, 32'h0,  32'h1001, 32'h0,   1, 32'h1000, 3'd3};
    v[7] = '{0,0,0,1, 32'hC00, 32'h0,  32'h0,    32'h201, 1, 32'hC00,  3'd5};
    v[8] = '{0,0,1,1, 32'hD00, 32'h0,  32'h102,  32'h200, 1, 32'hD00,  3'd5};
    v[9] = '{0,0,0,0, 32'hE00, 32'h0,  32'h0,    32'h0,   0, 32'hD00,  3'd0};
    // reset state, held across clock edges
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, RPC, 3'd0, 0, 0);
    @(negedge clk) rst_n = 1;
    step();
    chk_all("idle", 0, RPC, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      trap_req = v[i].trap; mret_req = v[i].mret; jalr_req = v[i].jalr; br_req = v[i].br;
      trap_vec = v[i].tv; mepc = v[i].ep; jalr_tgt = v[i].jt; br_tgt = v[i].bt;
      step();
      chk_all($sformatf("vec%0d", i), v[i].valid, v[i].pc, v[i].cause, v[i].valid, 0);
      @(negedge clk) clr();
      if (v[i].valid) begin
        step();
        chk_all($sformatf("vec%0d.f2", i), 0, v[i].pc, 3'd0, 1, 0);
        step();
        chk_all($sformatf("vec%0d.end", i), 0, v[i].pc, 3'd0, 0, 0);
      end
    end
    // branch, then trap during FLUSH restarts the count; jalr in FLUSH ignored
    @(negedge clk) br_req = 1; br_tgt = 32'h300; trap_vec = 32'hF00;
    step();
    chk_all("s3.br", 1, 32'h300, 3'd4, 1, 0);
    @(negedge clk) br_req = 0; trap_req = 1;
    step();
    chk_all("s3.trap", 1, 32'hF00, 3'd1, 1, 0);
    @(negedge clk) trap_req = 0; jalr_req = 1; jalr_tgt = 32'h400;
    step();
    chk_all("s3.f3", 0, 32'hF00, 3'd0, 1, 0);
    @(negedge clk) jalr_req = 0;
    step();
    chk_all("s3.end", 0, 32'hF00, 3'd0, 0, 0);
    // halt coincident with mret: redirect first, halt after the flush
    @(negedge clk) halt_req = 1; mret_req = 1; mepc = 32'h80;
    step();
    chk_all("s4.mret", 1, 32'h80, 3'd2, 1, 0);
    @(negedge clk) mret_req = 0;
    step();
    chk_all("s4.f2", 0, 32'h80, 3'd0, 1, 0);
    step();
    chk_all("s4.run", 0, 32'h80, 3'd0, 0, 0);
    step();
    chk_all("s4.halt", 0, 32'h80, 3'd0, 0, 1);
    // in HALT requests are ignored; dropping halt_req returns to RUN
    @(negedge clk) br_req = 1; br_tgt = 32'h500; trap_req = 1;
    step();
    chk_all("s6.ign", 0, 32'h80, 3'd0, 0, 1);
    @(negedge clk) clr(); halt_req = 0;
    step();
    chk_all("s6.run", 0, 32'h80, 3'd0, 0, 0);
    step();
    chk_all("s6.idle", 0, 32'h80, 3'd0, 0, 0);
    // reset during the second FLUSH cycle acts without a clock edge
    @(negedge clk) br_req = 1; br_tgt = 32'h600;
    step();
    chk_all("s5.br", 1, 32'h600, 3'd4, 1, 0);
    @(negedge clk) clr();
    step();
    chk_all("s5.f2", 0, 32'h600, 3'd0, 1, 0);
    #2 rst_n = 0;
    #1 chk_all("s5.async", 0, RPC, 3'd0, 0, 0);
    step();
    chk_all("s5.held", 0, RPC, 3'd0, 0, 0);
    // first edge after release samples requests
    @(negedge clk) rst_n = 1; jalr_req = 1; jalr_tgt = 32'h700;
    step();
    chk_all("s5.first", 1, 32'h700, 3'd3, 1, 0);
    @(negedge clk) clr();
    repeat (2) step();
    chk_all("s5.end", 0, 32'h700, 3'd0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
